// File: rtl/sequenciador_multiciclo_pkg.sv
// Shared definitions for the multicycle RISC-V control sequencer:
// state codes, state width, halt encoding and wait-counter sizing.
package sequenciador_multiciclo_pkg;

  localparam int STATE_W = 4;

  localparam logic [STATE_W-1:0] S_IF      = 4'd0;
  localparam logic [STATE_W-1:0] S_ID      = 4'd1;
  localparam logic [STATE_W-1:0] S_EX      = 4'd2;
  localparam logic [STATE_W-1:0] S_MEM     = 4'd3;
  localparam logic [STATE_W-1:0] S_WB      = 4'd4;
  localparam logic [STATE_W-1:0] S_WAIT_EX = 4'd5;
  localparam logic [STATE_W-1:0] S_WAIT_WB = 4'd6;
  localparam logic [STATE_W-1:0] S_SUMPC   = 4'd8;
  localparam logic [STATE_W-1:0] S_FIM     = 4'd9;
  localparam logic [STATE_W-1:0] S_HOLD    = 4'd10;

  localparam logic [31:0] HALT_INSTR = 32'h0;

  // Wide enough to count up to the longer of the two settle waits, never zero bits.
  function automatic int wait_cnt_w(input int ex_wait, input int wb_wait);
    int m;
    int w;
    m = (ex_wait > wb_wait) ? ex_wait : wb_wait;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sequenciador_multiciclo_contador.sv
// Saturating up-counter used for the cycle and retired-instruction counts.
module contador_saturado #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/sequenciador_multiciclo.sv
// Control sequencer for the multicycle datapath: walks IF..SUMPC with configurable
// settle waits, supports halt/resume and single-step, and counts cycles/instructions.
module sequenciador_multiciclo
  import sequenciador_multiciclo_pkg::*;
#(
  parameter int EX_WAIT = 2,
  parameter int WB_WAIT = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instrucao,
  input  logic               step_mode,
  input  logic               step_req,
  input  logic               resume,
  output logic [STATE_W-1:0] estado,
  output logic               pc_we,
  output logic               mem_en,
  output logic               reg_we_en,
  output logic               halted,
  output logic [CNT_W-1:0]   ciclos,
  output logic [CNT_W-1:0]   instrs
);

  localparam int WAIT_W    = wait_cnt_w(EX_WAIT, WB_WAIT);
  localparam int EX_LAST_I = (EX_WAIT > 0) ? EX_WAIT - 1 : 0;
  localparam int WB_LAST_I = (WB_WAIT > 0) ? WB_WAIT - 1 : 0;
  localparam logic [WAIT_W-1:0] EX_LAST = WAIT_W'(EX_LAST_I);
  localparam logic [WAIT_W-1:0] WB_LAST = WAIT_W'(WB_LAST_I);

  logic [STATE_W-1:0] estado_q;
  logic [STATE_W-1:0] estado_d;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [WAIT_W-1:0]  wait_cnt_d;
  logic               ciclos_inc;
  logic               instrs_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= S_IF;
      wait_cnt <= '0;
    end else begin
      estado_q <= estado_d;
      wait_cnt <= wait_cnt_d;
    end
  end

  // step_req and resume are level requests with no acknowledge: each is looked at
  // only while parked in HOLD or FIM respectively, and a high level leaves on that edge.
  // The wait counter defaults to 0 so it is already cleared on entry to a wait state.
  always_comb begin
    estado_d   = S_IF;
    wait_cnt_d = '0;
    case (estado_q)
      S_IF:    estado_d = S_ID;
      S_ID:    estado_d = (instrucao == HALT_INSTR) ? S_FIM : S_EX;
      S_EX:    estado_d = (EX_WAIT > 0) ? S_WAIT_EX : S_MEM;
      S_WAIT_EX: begin
        if (wait_cnt == EX_LAST) begin
          estado_d = S_MEM;
        end else begin
          estado_d   = S_WAIT_EX;
          wait_cnt_d = wait_cnt + WAIT_W'(1);
        end
      end
      S_MEM:   estado_d = S_WB;
      S_WB:    estado_d = (WB_WAIT > 0) ? S_WAIT_WB : S_SUMPC;
      S_WAIT_WB: begin
        if (wait_cnt == WB_LAST) begin
          estado_d = S_SUMPC;
        end else begin
          estado_d   = S_WAIT_WB;
          wait_cnt_d = wait_cnt + WAIT_W'(1);
        end
      end
      S_SUMPC: estado_d = step_mode ? S_HOLD : S_IF;
      S_HOLD:  estado_d = step_req ? S_IF : S_HOLD;
      S_FIM:   estado_d = resume ? S_IF : S_FIM;
      default: estado_d = S_IF;
    endcase
  end

  always_comb begin
    pc_we      = 1'b0;
    mem_en     = 1'b0;
    reg_we_en  = 1'b0;
    halted     = 1'b0;
    ciclos_inc = 1'b0;
    instrs_inc = 1'b0;
    case (estado_q)
      S_SUMPC: begin
        pc_we      = 1'b1;
        instrs_inc = 1'b1;
        ciclos_inc = 1'b1;
      end
      S_MEM: begin
        mem_en     = 1'b1;
        ciclos_inc = 1'b1;
      end
      S_WB: begin
        reg_we_en  = 1'b1;
        ciclos_inc = 1'b1;
      end
      S_FIM:   halted     = 1'b1;
      S_HOLD:  ciclos_inc = 1'b0;
      default: ciclos_inc = 1'b1;
    endcase
  end

  assign estado = estado_q;

  contador_saturado #(.W(CNT_W)) u_ciclos (
    .clk (clk),
    .rst (rst),
    .inc (ciclos_inc),
    .q   (ciclos)
  );

  contador_saturado #(.W(CNT_W)) u_instrs (
    .clk (clk),
    .rst (rst),
    .inc (instrs_inc),
    .q   (instrs)
  );

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Self-checking bench for sequenciador_multiciclo: three parameterisations driven in
// parallel, with a list-based reference model for the default instance.
module tb_sequenciador_multiciclo;

  typedef int seq_t[$];

  localparam int RUN  = 0;
  localparam int FIM  = 1;
  localparam int HOLD = 2;
  localparam int CMAX = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instrucao = 32'h0;
  logic        step_mode = 1'b0;
  logic        step_req  = 1'b0;
  logic        resume    = 1'b0;

  logic [3:0]  estado, estado_b, estado_c;
  logic        pc_we, mem_en, reg_we_en, halted;
  logic        pc_we_b, mem_en_b, reg_we_en_b, halted_b;
  logic        pc_we_c, mem_en_c, reg_we_en_c, halted_c;
  logic [15:0] ciclos, instrs, ciclos_b, instrs_b;
  logic [3:0]  ciclos_c, instrs_c;

  int errors = 0;
  int checks = 0;

  seq_t seq_a;
  seq_t seq_b;
  int   m_where;
  int   m_idx;
  int   m_cic;
  int   m_ins;

  always #5 clk = ~clk;

  sequenciador_multiciclo dut (
    .clk(clk), .rst(rst), .instrucao(instrucao), .step_mode(step_mode),
    .step_req(step_req), .resume(resume), .estado(estado), .pc_we(pc_we),
    .mem_en(mem_en), .reg_we_en(reg_we_en), .halted(halted),
    .ciclos(ciclos), .instrs(instrs)
  );

  sequenciador_multiciclo #(.EX_WAIT(0), .WB_WAIT(3)) dut_b (
    .clk(clk), .rst(rst), .instrucao(instrucao), .step_mode(step_mode),
    .step_req(step_req), .resume(resume), .estado(estado_b), .pc_we(pc_we_b),
    .mem_en(mem_en_b), .reg_we_en(reg_we_en_b), .halted(halted_b),
    .ciclos(ciclos_b), .instrs(instrs_b)
  );

  sequenciador_multiciclo #(.CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .instrucao(instrucao), .step_mode(step_mode),
    .step_req(step_req), .resume(resume), .estado(estado_c), .pc_we(pc_we_c),
    .mem_en(mem_en_c), .reg_we_en(reg_we_en_c), .halted(halted_c),
    .ciclos(ciclos_c), .instrs(instrs_c)
  );

  // Stage list of one instruction, IF through SUMPC, for the given settle waits.
  function automatic seq_t build_seq(input int exw, input int wbw);
    seq_t s;
    s = {0, 1, 2};
    for (int i = 0; i < exw; i++) s.push_back(5);
    s.push_back(3);
    s.push_back(4);
    for (int i = 0; i < wbw; i++) s.push_back(6);
    s.push_back(8);
    return s;
  endfunction

  function automatic int model_code();
    if (m_where == FIM)  return 9;
    if (m_where == HOLD) return 10;
    return seq_a[m_idx];
  endfunction

  function automatic logic [3:0] exp_dec(input int code);
    return {code == 8, code == 3, code == 4, code == 9};
  endfunction

  task automatic model_reset();
    m_where = RUN;
    m_idx   = 0;
    m_cic   = 0;
    m_ins   = 0;
  endtask

  task automatic model_step();
    int code;
    code = model_code();
    if (code != 9 && code != 10 && m_cic < CMAX) m_cic++;
    if (code == 8 && m_ins < CMAX) m_ins++;
    case (m_where)
      RUN: begin
        if (m_idx == 1 && instrucao == 32'h0) m_where = FIM;
        else if (m_idx == seq_a.size() - 1) begin
          m_idx = 0;
          if (step_mode) m_where = HOLD;
        end else m_idx++;
      end
      FIM:  if (resume)   begin m_where = RUN; m_idx = 0; end
      default: if (step_req) begin m_where = RUN; m_idx = 0; end
    endcase
  endtask

  // One clock: advance the model with the inputs seen at the edge, then settle.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (estado !== 4'd0) begin errors++; $display("FAIL reset_estado: got %0d want 0", estado); end
    checks++;
    if ({pc_we, mem_en, reg_we_en, halted} !== 4'b0) begin
      errors++; $display("FAIL reset_decoded: got %b want 0000", {pc_we, mem_en, reg_we_en, halted});
    end
    checks++;
    if (ciclos !== 16'd0 || instrs !== 16'd0) begin
      errors++; $display("FAIL reset_counters: got ciclos=%0d instrs=%0d want 0 0", ciclos, instrs);
    end
    checks++;
    if (estado_b !== 4'd0 || ciclos_c !== 4'd0) begin
      errors++; $display("FAIL reset_other: got estado_b=%0d ciclos_c=%0d want 0 0", estado_b, ciclos_c);
    end
    do_reset();
  endtask

  task automatic test_default_seq();
    int pc_cnt;
    do_reset();
    instrucao = 32'h0000_0013;
    step_mode = 1'b0;
    pc_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      cycle();
      if (pc_we === 1'b1) pc_cnt++;
      checks++;
      if (estado !== 4'(model_code()) || estado !== 4'(seq_a[k % 10])) begin
        errors++; $display("FAIL default_seq k=%0d: got %0d want %0d", k, estado, seq_a[k % 10]);
      end
      checks++;
      if ({pc_we, mem_en, reg_we_en, halted} !== exp_dec(model_code())) begin
        errors++; $display("FAIL default_decoded k=%0d: got %b want %b", k,
                           {pc_we, mem_en, reg_we_en, halted}, exp_dec(model_code()));
      end
      checks++;
      if (estado_b !== 4'(seq_b[k % 9])) begin
        errors++; $display("FAIL nowait_seq k=%0d: got %0d want %0d", k, estado_b, seq_b[k % 9]);
      end
      if (k == 9) begin
        checks++;
        if (instrs_b !== 16'd1) begin errors++; $display("FAIL nowait_instrs: got %0d want 1", instrs_b); end
      end
      if (k == 10) begin
        checks++;
        if (instrs !== 16'd1 || ciclos !== 16'd10) begin
          errors++; $display("FAIL default_counts: got ciclos=%0d instrs=%0d want 10 1", ciclos, instrs);
        end
      end
    end
    checks++;
    if (pc_cnt != 3) begin errors++; $display("FAIL pc_we_pulses: got %0d want 3", pc_cnt); end
  endtask

  task automatic test_halt();
    do_reset();
    instrucao = 32'h0;
    repeat (2) cycle();
    checks++;
    if (estado !== 4'd9 || halted !== 1'b1) begin
      errors++; $display("FAIL halt_enter: got estado=%0d halted=%b want 9 1", estado, halted);
    end
    for (int i = 0; i < 10; i++) begin
      instrucao = $urandom;
      step_req  = 1'($urandom_range(0, 1));
      cycle();
      checks++;
      if (estado !== 4'd9 || ciclos !== 16'd2 || ciclos !== 16'(m_cic)) begin
        errors++; $display("FAIL halt_frozen: got estado=%0d ciclos=%0d want 9 2", estado, ciclos);
      end
    end
    step_req  = 1'b0;
    instrucao = 32'h0000_0033;
    resume    = 1'b1;
    cycle();
    resume    = 1'b0;
    checks++;
    if (estado !== 4'd0 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_resume: got estado=%0d halted=%b want 0 0", estado, halted);
    end
    for (int i = 0; i < 12; i++) begin
      cycle();
      checks++;
      if (estado !== 4'(model_code()) || ciclos !== 16'(m_cic)) begin
        errors++; $display("FAIL after_resume: got estado=%0d ciclos=%0d want %0d %0d",
                           estado, ciclos, model_code(), m_cic);
      end
    end
  endtask

  task automatic test_step();
    do_reset();
    instrucao = 32'h0000_0093;
    step_mode = 1'b1;
    repeat (10) cycle();
    checks++;
    if (estado !== 4'd10 || instrs !== 16'd1) begin
      errors++; $display("FAIL step_hold: got estado=%0d instrs=%0d want 10 1", estado, instrs);
    end
    for (int i = 0; i < 20; i++) begin
      resume = 1'($urandom_range(0, 1));
      cycle();
      checks++;
      if (estado !== 4'd10 || ciclos !== 16'd10) begin
        errors++; $display("FAIL step_stall: got estado=%0d ciclos=%0d want 10 10", estado, ciclos);
      end
    end
    resume   = 1'b0;
    step_req = 1'b1;
    cycle();
    step_req = 1'b0;
    checks++;
    if (estado !== 4'd0) begin errors++; $display("FAIL step_release: got %0d want 0", estado); end
    repeat (10) cycle();
    checks++;
    if (estado !== 4'd10 || instrs !== 16'd2 || instrs !== 16'(m_ins)) begin
      errors++; $display("FAIL step_one_instr: got estado=%0d instrs=%0d want 10 2", estado, instrs);
    end
    step_mode = 1'b0;
  endtask

  task automatic test_saturation();
    int exp_c;
    int exp_i;
    do_reset();
    instrucao = 32'h0000_0013;
    step_mode = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      cycle();
      exp_c = (k < 15) ? k : 15;
      exp_i = (k / 10 < 15) ? k / 10 : 15;
      checks++;
      if (ciclos_c !== 4'(exp_c) || instrs_c !== 4'(exp_i)) begin
        errors++; $display("FAIL saturation k=%0d: got ciclos=%0d instrs=%0d want %0d %0d",
                           k, ciclos_c, instrs_c, exp_c, exp_i);
      end
    end
    checks++;
    if (ciclos !== 16'(m_cic) || instrs !== 16'(m_ins)) begin
      errors++; $display("FAIL wide_counts: got ciclos=%0d instrs=%0d want %0d %0d",
                         ciclos, instrs, m_cic, m_ins);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    instrucao = 32'h0000_0013;
    step_mode = 1'b0;
    repeat (17) cycle();
    checks++;
    if (estado !== 4'd6 || instrs !== 16'd1 || ciclos !== 16'd17) begin
      errors++; $display("FAIL pre_reset: got estado=%0d instrs=%0d ciclos=%0d want 6 1 17",
                         estado, instrs, ciclos);
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (estado !== 4'd0 || ciclos !== 16'd0 || instrs !== 16'd0) begin
      errors++; $display("FAIL mid_reset: got estado=%0d ciclos=%0d instrs=%0d want 0 0 0",
                         estado, ciclos, instrs);
    end
    #2 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      checks++;
      if (estado !== 4'(model_code()) || ciclos !== 16'(m_cic) || instrs !== 16'(m_ins)) begin
        errors++; $display("FAIL post_reset: got estado=%0d ciclos=%0d instrs=%0d want %0d %0d %0d",
                           estado, ciclos, instrs, model_code(), m_cic, m_ins);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      instrucao = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h1);
      step_mode = ($urandom_range(0, 3) == 0);
      step_req  = ($urandom_range(0, 2) == 0);
      resume    = ($urandom_range(0, 2) == 0);
      cycle();
      checks++;
      if (estado !== 4'(model_code()) ||
          {pc_we, mem_en, reg_we_en, halted} !== exp_dec(model_code()) ||
          ciclos !== 16'(m_cic) || instrs !== 16'(m_ins)) begin
        errors++; $display("FAIL random i=%0d: got estado=%0d dec=%b ciclos=%0d instrs=%0d want %0d %b %0d %0d",
                           i, estado, {pc_we, mem_en, reg_we_en, halted}, ciclos, instrs,
                           model_code(), exp_dec(model_code()), m_cic, m_ins);
      end
    end
    step_mode = 1'b0;
    step_req  = 1'b0;
    resume    = 1'b0;
  endtask

  initial begin
    seq_a = build_seq(2, 2);
    seq_b = build_seq(0, 3);
    model_reset();
    test_reset();
    test_default_seq();
    test_halt();
    test_step();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
